// File: rtl/dvfs_pkg.sv
// Shared DVFS definitions: level width, governor state encoding and default
// workload thresholds, reused by the per-core DVFS array.
package dvfs_pkg;

  localparam int unsigned LVL_W    = 32'd2;
  localparam int unsigned DEF_TH1  = 32'd10000;
  localparam int unsigned DEF_TH2  = 32'd50000;
  localparam int unsigned DEF_TH3  = 32'd100000;
  localparam int unsigned DEF_HYST = 32'd2000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_V_UP   = 3'd1,
    ST_F_UP   = 3'd2,
    ST_F_DOWN = 3'd3,
    ST_V_DOWN = 3'd4,
    ST_DWELL  = 3'd5
  } dvfs_state_e;

endpackage

// File: rtl/dvfs_level_map.sv
// Combinational workload-to-level map with down-step hysteresis: rises jump
// straight to the raw level, falls stop at the highest level still held.
module dvfs_level_map
  import dvfs_pkg::*;
#(
  parameter int unsigned WL_W  = 32'd32,
  parameter int unsigned LVL_W = dvfs_pkg::LVL_W,
  parameter int unsigned TH1   = DEF_TH1,
  parameter int unsigned TH2   = DEF_TH2,
  parameter int unsigned TH3   = DEF_TH3,
  parameter int unsigned HYST  = DEF_HYST
) (
  input  logic [WL_W-1:0]  workload,
  input  logic [LVL_W-1:0] cur,
  output logic [LVL_W-1:0] target
);

  localparam logic [WL_W-1:0] T1 = WL_W'(TH1);
  localparam logic [WL_W-1:0] T2 = WL_W'(TH2);
  localparam logic [WL_W-1:0] T3 = WL_W'(TH3);
  // A level L is held on the way down while workload stays above TH(L) - HYST.
  localparam logic [WL_W-1:0] H1 = WL_W'(TH1 - HYST);
  localparam logic [WL_W-1:0] H2 = WL_W'(TH2 - HYST);
  localparam logic [WL_W-1:0] H3 = WL_W'(TH3 - HYST);

  logic [LVL_W-1:0] raw_s;

  // Raw level from plain threshold comparison.
  always_comb begin
    if (workload > T3) begin
      raw_s = LVL_W'(3);
    end else if (workload > T2) begin
      raw_s = LVL_W'(2);
    end else if (workload > T1) begin
      raw_s = LVL_W'(1);
    end else begin
      raw_s = LVL_W'(0);
    end
  end

  // Target level with hysteresis applied only when stepping down.
  always_comb begin
    target = cur;
    if (raw_s > cur) begin
      target = raw_s;
    end else if (raw_s < cur) begin
      if ((cur >= LVL_W'(3)) && (workload > H3)) begin
        target = LVL_W'(3);
      end else if ((cur >= LVL_W'(2)) && (workload > H2)) begin
        target = LVL_W'(2);
      end else if ((cur >= LVL_W'(1)) && (workload > H1)) begin
        target = LVL_W'(1);
      end else begin
        target = LVL_W'(0);
      end
    end else begin
      target = cur;
    end
  end

endmodule

// File: rtl/dvfs_governor.sv
// DVFS governor: hysteresis level selection, ordered voltage/frequency
// handshakes, post-transition dwell and sticky ack-timeout detection.
module dvfs_governor
  import dvfs_pkg::*;
#(
  parameter int unsigned WL_W           = 32'd32,
  parameter int unsigned LVL_W          = dvfs_pkg::LVL_W,
  parameter int unsigned TH1            = DEF_TH1,
  parameter int unsigned TH2            = DEF_TH2,
  parameter int unsigned TH3            = DEF_TH3,
  parameter int unsigned HYST           = DEF_HYST,
  parameter int unsigned DWELL_CYCLES   = 32'd16,
  parameter int unsigned TIMEOUT_CYCLES = 32'd1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WL_W-1:0]  workload,
  input  logic             workload_valid,
  input  logic             v_ack,
  input  logic             f_ack,
  output logic [LVL_W-1:0] voltage_level,
  output logic [LVL_W-1:0] frequency_level,
  output logic             v_req,
  output logic             f_req,
  output logic             busy,
  output logic             level_done,
  output logic             err_timeout
);

  localparam int unsigned CNT_MAX = (DWELL_CYCLES > TIMEOUT_CYCLES) ? DWELL_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 32'd1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 32'd1);

  dvfs_state_e      state_r;
  dvfs_state_e      next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [LVL_W-1:0] target_s;
  logic             raise_s;
  logic             lower_s;
  logic             tmo_hit_s;
  logic             dwell_end_s;
  logic [LVL_W-1:0] vlvl_s;
  logic [LVL_W-1:0] flvl_s;
  logic             vreq_s;
  logic             freq_s;
  logic             done_s;
  logic             err_s;

  // The frequency level is the level the core is actually running at.
  dvfs_level_map #(
    .WL_W (WL_W),
    .LVL_W(LVL_W),
    .TH1  (TH1),
    .TH2  (TH2),
    .TH3  (TH3),
    .HYST (HYST)
  ) u_level_map (
    .workload(workload),
    .cur     (frequency_level),
    .target  (target_s)
  );

  assign raise_s     = workload_valid && (target_s > frequency_level);
  assign lower_s     = workload_valid && (target_s < frequency_level);
  assign tmo_hit_s   = (cnt_r == TMO_LAST);
  assign dwell_end_s = (cnt_r == DWELL_LAST);
  assign busy        = (state_r != ST_IDLE);

  // State register and shared dwell/timeout counter, cleared on every state change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= next_state_s;
      if ((next_state_s != state_r) || (state_r == ST_IDLE)) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (raise_s) begin
          next_state_s = ST_V_UP;
        end else if (lower_s) begin
          next_state_s = ST_F_DOWN;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_V_UP: begin
        if (v_ack) begin
          next_state_s = ST_F_UP;
        end else if (tmo_hit_s) begin
          next_state_s = ST_DWELL;
        end else begin
          next_state_s = ST_V_UP;
        end
      end
      ST_F_UP: begin
        if (f_ack || tmo_hit_s) begin
          next_state_s = ST_DWELL;
        end else begin
          next_state_s = ST_F_UP;
        end
      end
      ST_F_DOWN: begin
        if (f_ack) begin
          next_state_s = ST_V_DOWN;
        end else if (tmo_hit_s) begin
          next_state_s = ST_DWELL;
        end else begin
          next_state_s = ST_F_DOWN;
        end
      end
      ST_V_DOWN: begin
        if (v_ack || tmo_hit_s) begin
          next_state_s = ST_DWELL;
        end else begin
          next_state_s = ST_V_DOWN;
        end
      end
      ST_DWELL: begin
        if (dwell_end_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DWELL;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Next output values; a level only moves on the edge its req rises.
  always_comb begin
    vlvl_s = voltage_level;
    flvl_s = frequency_level;
    vreq_s = v_req;
    freq_s = f_req;
    done_s = 1'b0;
    err_s  = err_timeout;
    case (state_r)
      ST_IDLE: begin
        if (raise_s) begin
          vlvl_s = target_s;
          vreq_s = 1'b1;
        end else if (lower_s) begin
          flvl_s = target_s;
          freq_s = 1'b1;
        end else begin
          vreq_s = 1'b0;
          freq_s = 1'b0;
        end
      end
      ST_V_UP: begin
        if (v_ack) begin
          vreq_s = 1'b0;
          flvl_s = voltage_level;
          freq_s = 1'b1;
        end else if (tmo_hit_s) begin
          vreq_s = 1'b0;
          err_s  = 1'b1;
        end else begin
          vreq_s = 1'b1;
        end
      end
      ST_F_UP: begin
        if (f_ack) begin
          freq_s = 1'b0;
          done_s = 1'b1;
        end else if (tmo_hit_s) begin
          freq_s = 1'b0;
          err_s  = 1'b1;
        end else begin
          freq_s = 1'b1;
        end
      end
      ST_F_DOWN: begin
        if (f_ack) begin
          freq_s = 1'b0;
          vlvl_s = frequency_level;
          vreq_s = 1'b1;
        end else if (tmo_hit_s) begin
          freq_s = 1'b0;
          err_s  = 1'b1;
        end else begin
          freq_s = 1'b1;
        end
      end
      ST_V_DOWN: begin
        if (v_ack) begin
          vreq_s = 1'b0;
          done_s = 1'b1;
        end else if (tmo_hit_s) begin
          vreq_s = 1'b0;
          err_s  = 1'b1;
        end else begin
          vreq_s = 1'b1;
        end
      end
      ST_DWELL: begin
        vreq_s = 1'b0;
        freq_s = 1'b0;
      end
      default: begin
        vreq_s = 1'b0;
        freq_s = 1'b0;
      end
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      voltage_level   <= '0;
      frequency_level <= '0;
      v_req           <= 1'b0;
      f_req           <= 1'b0;
      level_done      <= 1'b0;
      err_timeout     <= 1'b0;
    end else begin
      voltage_level   <= vlvl_s;
      frequency_level <= flvl_s;
      v_req           <= vreq_s;
      f_req           <= freq_s;
      level_done      <= done_s;
      err_timeout     <= err_s;
    end
  end

endmodule

// File: tb/tb_dvfs_governor.sv
// Scoreboard bench for dvfs_governor: a transaction-level level model queues
// expected completions, a negedge monitor checks them and the handshake rules.
module tb_dvfs_governor;

  localparam int TH1  = 10000;
  localparam int TH2  = 50000;
  localparam int TH3  = 100000;
  localparam int HYST = 2000;
  localparam int DWELL = 16;
  localparam int TMO  = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] workload = 32'd0;
  logic        workload_valid = 1'b0;
  logic        v_ack = 1'b0;
  logic        f_ack = 1'b0;
  logic [1:0]  voltage_level;
  logic [1:0]  frequency_level;
  logic        v_req, f_req, busy, level_done, err_timeout;

  typedef struct {
    bit is_to;
    int v;
    int f;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cur_v = 0;
  int   cur_f = 0;
  int   ack_mode = 0;
  int   th[4];

  dvfs_governor #(
    .WL_W(32), .LVL_W(2), .TH1(TH1), .TH2(TH2), .TH3(TH3), .HYST(HYST),
    .DWELL_CYCLES(DWELL), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .workload(workload), .workload_valid(workload_valid),
    .v_ack(v_ack), .f_ack(f_ack), .voltage_level(voltage_level),
    .frequency_level(frequency_level), .v_req(v_req), .f_req(f_req), .busy(busy),
    .level_done(level_done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int raw_lvl(input int unsigned w);
    for (int l = 3; l >= 1; l--) if (w > th[l]) return l;
    return 0;
  endfunction

  function automatic int tgt(input int unsigned w, input int c);
    int r;
    r = raw_lvl(w);
    if (r > c) return r;
    if (r < c) begin
      for (int l = c; l >= 1; l--) if (w > th[l] - HYST) return l;
      return 0;
    end
    return c;
  endfunction

  // Random acknowledge generator for the randomized phase.
  always @(posedge clk) begin
    if (ack_mode == 1) begin
      #1;
      v_ack = ($urandom_range(0, 3) != 0);
      f_ack = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor state.
  bit   skip = 1'b1;
  logic pv_req, pf_req, perr;
  logic [1:0] pvl, pfl;
  int   vreq_run = 0;
  int   dwell_cnt = 0;
  bit   dwell_track = 1'b0;
  exp_t e;

  always @(negedge clk) begin
    if (!rst_n) begin
      skip = 1'b1;
      dwell_track = 1'b0;
      vreq_run = 0;
    end else begin
      if (!skip) begin
        check("freq_le_volt", int'(frequency_level <= voltage_level), 1);
        if (pv_req) check("v_level_stable", voltage_level, pvl);
        if (pf_req) check("f_level_stable", frequency_level, pfl);
        if (perr) check("err_sticky", err_timeout, 1);
        if (dwell_track) begin
          if (busy) dwell_cnt++;
          else begin
            check("dwell_len", dwell_cnt, DWELL);
            dwell_track = 1'b0;
          end
        end
        if (level_done) begin
          check("done_expected", int'(q.size() > 0), 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            check("done_kind", e.is_to, 0);
            check("done_vlevel", voltage_level, e.v);
            check("done_flevel", frequency_level, e.f);
          end
          dwell_track = 1'b1;
          dwell_cnt = 1;
        end
        if (err_timeout && !perr) begin
          check("timeout_expected", int'(q.size() > 0), 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            check("timeout_kind", e.is_to, 1);
            check("timeout_vlevel", voltage_level, e.v);
            check("timeout_flevel", frequency_level, e.f);
          end
          check("timeout_len", vreq_run, TMO);
          check("timeout_vreq_low", v_req, 0);
          dwell_track = 1'b1;
          dwell_cnt = 1;
        end
      end
      vreq_run = v_req ? vreq_run + 1 : 0;
      skip = 1'b0;
      pv_req = v_req;
      pf_req = f_req;
      perr = err_timeout;
      pvl = voltage_level;
      pfl = frequency_level;
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    q.delete();
    cur_v = 0;
    cur_f = 0;
    @(negedge clk);
    check("rst_vlevel", voltage_level, 0);
    check("rst_flevel", frequency_level, 0);
    check("rst_reqs", {v_req, f_req}, 0);
    check("rst_busy", busy, 0);
    check("rst_done", level_done, 0);
    check("rst_err", err_timeout, 0);
  endtask

  // Issue one sample while idle; to_mode means the voltage ack will never come.
  task automatic send(input int unsigned w, input bit to_mode);
    int t;
    @(posedge clk);
    #1 workload = w;
    workload_valid = 1'b1;
    @(posedge clk);
    #1 workload_valid = 1'b0;
    t = tgt(w, cur_f);
    if (t != cur_f) begin
      if (to_mode) begin
        q.push_back('{1'b1, t, cur_f});
        cur_v = t;
      end else begin
        q.push_back('{1'b0, t, t});
        cur_v = t;
        cur_f = t;
      end
    end
    @(negedge clk);
    check("accept_busy", busy, int'(t != tgt(w, t) || q.size() > 0));
  endtask

  task automatic wait_idle(input bit inject);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(posedge clk);
      #1;
      workload = $urandom_range(0, 300000);
      workload_valid = inject && ($urandom_range(0, 3) == 0);
      @(negedge clk);
      n++;
    end
    workload_valid = 1'b0;
    check("idle_reached", int'(n < 3000), 1);
    check("idle_vlevel", voltage_level, cur_v);
    check("idle_flevel", frequency_level, cur_f);
  endtask

  initial begin
    int n;
    int w;
    th[0] = 0;
    th[1] = TH1;
    th[2] = TH2;
    th[3] = TH3;
    v_ack = 1'b1;
    f_ack = 1'b1;
    do_reset();

    // Directed: raise, hysteresis hold, step down, floor, multi-step jump.
    send(60000, 1'b0);  wait_idle(1'b0);
    send(49000, 1'b0);  wait_idle(1'b0);
    send(47000, 1'b0);  wait_idle(1'b0);
    send(0, 1'b0);      wait_idle(1'b0);
    send(200000, 1'b0); wait_idle(1'b1);
    send(9000, 1'b0);   wait_idle(1'b1);

    // Randomized workloads and acks, with ignored samples while busy.
    ack_mode = 1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        w = $urandom_range(0, 300000);
      end else begin
        w = th[$urandom_range(0, 3)] + int'($urandom_range(0, 8000)) - 4000;
        if (w < 0) w = 0;
      end
      send(w, 1'b0);
      wait_idle(1'b1);
    end

    // Voltage ack never arrives.
    ack_mode = 0;
    @(negedge clk);
    v_ack = 1'b1;
    f_ack = 1'b1;
    do_reset();
    v_ack = 1'b0;
    send(60000, 1'b1);
    wait_idle(1'b0);
    check("err_set", err_timeout, 1);
    repeat (20) @(negedge clk);
    check("err_held", err_timeout, 1);

    // Reset in the middle of the frequency handshake.
    v_ack = 1'b1;
    f_ack = 1'b0;
    send(200000, 1'b0);
    n = 0;
    while (!f_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("f_up_reached", int'(n < 100), 1);
    check("f_up_busy", busy, 1);
    do_reset();

    f_ack = 1'b1;
    send(60000, 1'b0);
    wait_idle(1'b0);
    check("queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
